controle_alarme: RTL
====================

CONTROLE_ALARME -- requirements
Module: controle_alarme

Interface
REQ-001 SHALL have parameter EXIT_DLY, default 4: exit delay in clock cycles (>=1).
REQ-002 SHALL have parameter ENTRY_DLY, default 4: entry delay in clock cycles (>=1).
REQ-003 SHALL have parameter SIREN_TIME, default 8: siren-on duration in clock cycles (>=1).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port trigger  input  1  2-of-3 sensor vote from the upstream voter, asynchronous to clk.
REQ-007 SHALL have port arm  input  1  arm request, sampled each cycle.
REQ-008 SHALL have port disarm  input  1  disarm request, sampled each cycle.
REQ-009 SHALL have port ack  input  1  siren acknowledge/silence.
REQ-010 SHALL have port siren  output  1  alarm siren drive.
REQ-011 SHALL have port armed  output  1  high in every state except DESARMADO.
REQ-012 SHALL have port state_o  output  3  current state encoding.
REQ-013 SHALL have port event_cnt  output  8  number of DISPARO entries.

Function
REQ-014 SHALL pass trigger through a 2-flop synchronizer; trig_s is the second stage; trigger-to-trig_s latency 2 cycles.
REQ-015 SHALL implement states DESARMADO=0, ARMANDO=1, ARMADO=2, ATRASO=3, DISPARO=4, BLOQUEIO=5; codes 6-7 SHALL return to DESARMADO next cycle.
REQ-016 SHALL, with disarm=1 in any state, go to DESARMADO next cycle; disarm has priority over arm, trig_s, ack and timer expiry in the same cycle.
REQ-017 SHALL go DESARMADO -> ARMANDO on arm=1; arm is ignored in all other states.
REQ-018 SHALL stay in ARMANDO exactly EXIT_DLY cycles, ignoring trig_s, then go to ARMADO.
REQ-019 SHALL go ARMADO -> ATRASO in the cycle after trig_s=1 is sampled.
REQ-020 SHALL stay in ATRASO exactly ENTRY_DLY cycles, then go to DISPARO; trig_s deassertion does not cancel ATRASO.
REQ-021 SHALL assert siren registered, exactly while in DISPARO, for SIREN_TIME cycles, then go to BLOQUEIO.
REQ-022 SHALL, on ack=1 in DISPARO, go to BLOQUEIO next cycle; ack is ignored elsewhere.
REQ-023 SHALL go BLOQUEIO -> DISPARO on a trig_s rising edge (0 in previous cycle, 1 now), with a full SIREN_TIME reload; a steady trig_s=1 does not retrigger.
REQ-024 SHALL reload the shared down-counter on every state entry; expiry is counter==0 while in the state.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force state DESARMADO, siren=0, armed=0, state_o=0, event_cnt=0, synchronizer flops=0, timer=0.
REQ-026 SHALL, on reset mid-ATRASO or mid-DISPARO, drop siren immediately and resume only via a new arm after rst_n=1.

Configuration
REQ-027 SHALL, with macro CONTROLE_ALARME_CONTADOR_EN defined, increment event_cnt by 1 on each entry to DISPARO, saturating at 255, cleared only by reset.
REQ-028 SHALL, without CONTROLE_ALARME_CONTADOR_EN, tie event_cnt to 0 with no counter flops.

Structure
REQ-029 SHALL place the state encodings and width constants (state 3 bits, counter 8 bits) in shared package alarme_pkg.
REQ-030 SHALL implement the loadable down-counter as sub-module temporizador (load, value, zero flag).

Verification (default parameters)
REQ-031 SHALL check: arm=1 one cycle -> ARMANDO 4 cycles, ARMADO; trigger pulses during ARMANDO produce no ATRASO.
REQ-032 SHALL check: in ARMADO trigger=1 -> ATRASO 3 cycles later (2 sync + 1), siren=1 after 4 more cycles, held 8 cycles, then BLOQUEIO with siren=0, armed=1.
REQ-033 SHALL check: disarm=1 in ATRASO cycle 2 -> DESARMADO next cycle, siren never asserted, event_cnt unchanged.
REQ-034 SHALL check: ack=1 in DISPARO cycle 3 -> siren=0 next cycle; trigger 0->1 in BLOQUEIO -> DISPARO again, event_cnt=2.
REQ-035 SHALL check: arm=1 and disarm=1 same cycle from DESARMADO -> stays DESARMADO; rst_n=0 mid-DISPARO -> siren=0 without waiting for clk.
REQ-036 SHALL check: 260 DISPARO entries with CONTROLE_ALARME_CONTADOR_EN -> event_cnt=255; without the macro -> event_cnt=0.

Source files
------------

// File: rtl/alarme_pkg.sv
// Shared constants, state encodings and the delay-to-load helper for the alarm controller.
package alarme_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      DESARMADO = 3'd0,
      ARMANDO   = 3'd1,
      ARMADO    = 3'd2,
      ATRASO    = 3'd3,
      DISPARO   = 3'd4,
      BLOQUEIO  = 3'd5
   } state_t;

   // Timer expires on the last cycle in a state, so it is loaded with N-1.
   function automatic logic [CNT_W-1:0] dly_load(input int unsigned cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/controle_alarme_temporizador.sv
// Loadable down-counter shared by all timed states; zero flags expiry.
module temporizador
   import alarme_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/controle_alarme.sv
// Intrusion alarm controller: arm/exit delay, entry delay, timed siren, lockout with retrigger.
// Optional DISPARO entry counter enabled by macro CONTROLE_ALARME_CONTADOR_EN.
module controle_alarme
   import alarme_pkg::*;
#(
   parameter int unsigned EXIT_DLY   = 4,
   parameter int unsigned ENTRY_DLY  = 4,
   parameter int unsigned SIREN_TIME = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               trigger,
   input  logic               arm,
   input  logic               disarm,
   input  logic               ack,
   output logic               siren,
   output logic               armed,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   event_cnt
);

   state_t           state;
   state_t           next;
   logic             sync1;
   logic             trig_s;
   logic             trig_prev;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b0;
         trig_s    <= 1'b0;
         trig_prev <= 1'b0;
      end else begin
         sync1     <= trigger;
         trig_s    <= sync1;
         trig_prev <= trig_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DESARMADO;
         siren <= 1'b0;
      end else begin
         state <= next;
         siren <= (next == DISPARO);
      end
   end

   always_comb begin
      next = state;
      if (disarm) begin
         next = DESARMADO;
      end else begin
         case (state)
            DESARMADO: if (arm)                  next = ARMANDO;
            ARMANDO:   if (tmr_zero)             next = ARMADO;
            ARMADO:    if (trig_s)               next = ATRASO;
            ATRASO:    if (tmr_zero)             next = DISPARO;
            DISPARO:   if (ack || tmr_zero)      next = BLOQUEIO;
            BLOQUEIO:  if (trig_s && !trig_prev) next = DISPARO;
            default:                             next = DESARMADO;
         endcase
      end
   end

   // Every state change is an entry, so the timer reloads for the state being entered.
   always_comb begin
      tmr_load  = (next != state);
      tmr_value = '0;
      case (next)
         ARMANDO: tmr_value = dly_load(EXIT_DLY);
         ATRASO:  tmr_value = dly_load(ENTRY_DLY);
         DISPARO: tmr_value = dly_load(SIREN_TIME);
         default: tmr_value = '0;
      endcase
   end

   temporizador u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .value (tmr_value),
      .zero  (tmr_zero)
   );

   assign armed   = (state != DESARMADO);
   assign state_o = state;

`ifdef CONTROLE_ALARME_CONTADOR_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (next == DISPARO && state != DISPARO && cnt != '1) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign event_cnt = cnt;
`else
   assign event_cnt = '0;
`endif

endmodule
